// File: rtl/debug_event_log.sv
// debug_event_log: Wishbone pipelined target that timestamps 8-bit debounced
// input snapshots into an event FIFO for software to drain.
//
// Register map (word address adr_i):
//   0 EVENT  : write pushes {timestamp, data[7:0]}; read pops the oldest entry
//   1 STATUS : read {ovf[18], full[17], empty[16], count[8:0]};
//              write bit0 clears overflow, bit1 flushes the FIFO
//   2 TIME   : read the current timestamp, write ignored
//   3        : reads 0, write ignored
//
// Handshake: a request is accepted on every clock edge where cyc_i && stb_i
// are high (stall_o is constantly 0). All side effects happen on that edge.
// ack_o and dat_o follow one cycle later. ack_o is masked by cyc_i, so an
// abandoned cycle sees no ack even though the side effect already happened.
//
// Optional build macro: DEBUG_EVENT_LOG_DEDUP_EN. When it is defined, an EVENT
// write whose data equals the last pushed data is acknowledged but not stored.
module debug_event_log #(
  parameter int DEPTH    = 16,
  parameter int TICK_DIV = 100_000,
  parameter int TS_WIDTH = 24
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [1:0]  adr_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  output logic        ack_o,
  output logic        stall_o,
  output logic [7:0]  last_event_o,
  output logic        irq_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICK_DIV - 1);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [8:0]       DEPTH_CNT = 9'(DEPTH);

  localparam logic [1:0] ADR_EVENT  = 2'd0;
  localparam logic [1:0] ADR_STATUS = 2'd1;
  localparam logic [1:0] ADR_TIME   = 2'd2;

  // Timebase state
  logic [PRE_W-1:0]    presc_q, presc_d;
  logic [TS_WIDTH-1:0] ts_q, ts_d;

  // FIFO state
  logic [31:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [8:0]       count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             push;
  logic [31:0]      push_data;

  // Bus response and side outputs
  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
  logic [7:0]  last_q, last_d;
  logic        irq_q, irq_d;

  // Request decode
  logic req;
  logic fifo_full;
  logic fifo_empty;
  logic is_dup;

  assign req        = cyc_i & stb_i;
  assign fifo_full  = (count_q == DEPTH_CNT);
  assign fifo_empty = (count_q == 9'd0);

`ifdef DEBUG_EVENT_LOG_DEDUP_EN
  // Data of the last accepted push; duplicates of it are not stored.
  logic [7:0] dedup_q, dedup_d;
  assign is_dup = (dat_i[7:0] == dedup_q);
`else
  assign is_dup = 1'b0;
`endif

  // Upper write-data bits carry no meaning for any register.
  logic unused_dat;
  assign unused_dat = ^dat_i[31:8];

  // Free-running prescaler; the timestamp advances once per TICK_DIV cycles.
  always_comb begin
    presc_d = presc_q;
    ts_d    = ts_q;
    if (presc_q == PRE_LAST) begin
      presc_d = '0;
      ts_d    = ts_q + TS_WIDTH'(1);
    end else begin
      presc_d = presc_q + PRE_W'(1);
    end
  end

  // Register access: decode the accepted request into FIFO and flag updates
  // plus the read data returned with the ack.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    last_d    = last_q;
    push      = 1'b0;
    push_data = {24'(ts_q), dat_i[7:0]};
    ack_d     = req;
    dat_d     = 32'd0;
`ifdef DEBUG_EVENT_LOG_DEDUP_EN
    dedup_d   = dedup_q;
`endif

    if (req) begin
      unique case (adr_i)
        ADR_EVENT: begin
          if (we_i) begin
            // The LED mirror follows every write, stored or not.
            last_d = dat_i[7:0];
            if (is_dup) begin
              // Repeated value: acknowledged, nothing stored, no overflow.
            end else if (fifo_full) begin
              ovf_d = 1'b1;
            end else begin
              push     = 1'b1;
              wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
              count_d  = count_q + 9'd1;
`ifdef DEBUG_EVENT_LOG_DEDUP_EN
              dedup_d  = dat_i[7:0];
`endif
            end
          end else if (!fifo_empty) begin
            dat_d    = mem_q[rd_ptr_q];
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
            count_d  = count_q - 9'd1;
          end
        end
        ADR_STATUS: begin
          if (we_i) begin
            if (dat_i[0]) begin
              ovf_d = 1'b0;
            end
            if (dat_i[1]) begin
              wr_ptr_d = '0;
              rd_ptr_d = '0;
              count_d  = 9'd0;
`ifdef DEBUG_EVENT_LOG_DEDUP_EN
              dedup_d  = 8'd0;
`endif
            end
          end else begin
            // Reports the state before this request's own side effect.
            dat_d = {13'd0, ovf_q, fifo_full, fifo_empty, 7'd0, count_q};
          end
        end
        ADR_TIME: begin
          if (!we_i) begin
            dat_d = 32'(ts_q);
          end
        end
        default: begin
          // Reserved word: reads 0, writes have no effect.
        end
      endcase
    end

    irq_d = (count_d != 9'd0);
  end

  // State registers with synchronous reset; a reset drops any pending ack.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      presc_q  <= '0;
      ts_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= 9'd0;
      ovf_q    <= 1'b0;
      ack_q    <= 1'b0;
      dat_q    <= 32'd0;
      last_q   <= 8'd0;
      irq_q    <= 1'b0;
`ifdef DEBUG_EVENT_LOG_DEDUP_EN
      dedup_q  <= 8'd0;
`endif
    end else begin
      presc_q  <= presc_d;
      ts_q     <= ts_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      last_q   <= last_d;
      irq_q    <= irq_d;
`ifdef DEBUG_EVENT_LOG_DEDUP_EN
      dedup_q  <= dedup_d;
`endif
    end
  end

  // FIFO storage; contents are meaningless outside the pointer window, so
  // the array itself needs no reset.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign ack_o        = ack_q & cyc_i;
  assign dat_o        = dat_q;
  assign stall_o      = 1'b0;
  assign last_event_o = last_q;
  assign irq_o        = irq_q;

endmodule
